// File: rtl/wb_gpio_btn.sv
// wb_gpio_btn: Wishbone classic slave for LED[7:0], debounced SW[3:0]/BTN[2:0], sticky rising-edge capture and masked irq.
// Define WB_GPIO_LED_BLINK_EN to add per-LED blink enables in LED register bits [15:8].
module wb_gpio_btn #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 24,
  parameter int BLINK_BIT = 23
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  input  logic [3:0]  sw_i,
  input  logic [2:0]  btn_i,
  output logic [7:0]  led_o,
  output logic        irq_o
);
  logic [6:0] r_sync1, r_sync2, r_deb, r_edge, r_mask, w_deb_nxt, w_rise, w_w1c;
  logic [7:0] r_led, w_blink, w_led_nxt;
  logic [CNT_W-1:0] r_cnt [7];
  logic [CNT_W-1:0] w_cnt_nxt [7];
  logic [31:0] w_rdat;
  logic [1:0] w_adr;
  logic w_req, w_wr0, w_unused;
  assign w_adr = wb_adr_i[3:2];
  assign w_req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign w_wr0 = w_req & wb_we_i & wb_sel_i[0];
  assign w_w1c = (w_wr0 && w_adr == 2'd2) ? wb_dat_i[6:0] : 7'd0;
  // A counter that reaches its limit while the input still disagrees commits the new level and restarts.
  always_comb begin
    for (int k = 0; k < 7; k++) begin
      w_deb_nxt[k] = (r_sync2[k] != r_deb[k] && r_cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) ? r_sync2[k] : r_deb[k];
      w_cnt_nxt[k] = (r_sync2[k] == r_deb[k] || r_cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) ? '0 : r_cnt[k] + CNT_W'(1);
    end
  end
  assign w_rise = w_deb_nxt & ~r_deb;
  assign w_rdat = w_adr == 2'd0 ? {16'd0, w_blink, r_led} :
                  w_adr == 2'd1 ? {25'd0, r_deb} :
                  w_adr == 2'd2 ? {25'd0, r_edge} : {25'd0, r_mask};
`ifdef WB_GPIO_LED_BLINK_EN
  logic [7:0] r_blink;
  logic [CNT_W-1:0] r_free;
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_blink <= '0;
      r_free <= '0;
    end else begin
      r_free <= r_free + CNT_W'(1);
      if (w_req && wb_we_i && wb_sel_i[1] && w_adr == 2'd0) r_blink <= wb_dat_i[15:8];
    end
  end
  assign w_blink = r_blink;
  assign w_led_nxt = r_led & (~r_blink | {8{r_free[BLINK_BIT]}});
  assign w_unused = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};
`else
  assign w_blink = 8'd0;
  assign w_led_nxt = r_led;
  assign w_unused = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1], BLINK_BIT[0]};
`endif
  // Set beats W1C on the same edge; read data is the pre-update register value.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb <= '0;
      r_edge <= '0;
      r_mask <= '0;
      r_led <= '0;
      for (int k = 0; k < 7; k++) r_cnt[k] <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      led_o <= '0;
      irq_o <= 1'b0;
    end else begin
      r_sync1 <= {btn_i, sw_i};
      r_sync2 <= r_sync1;
      r_deb <= w_deb_nxt;
      for (int k = 0; k < 7; k++) r_cnt[k] <= w_cnt_nxt[k];
      r_edge <= (r_edge & ~w_w1c) | w_rise;
      irq_o <= |(r_edge & r_mask);
      led_o <= w_led_nxt;
      wb_ack_o <= w_req;
      if (w_req) wb_dat_o <= w_rdat;
      if (w_wr0 && w_adr == 2'd0) r_led <= wb_dat_i[7:0];
      if (w_wr0 && w_adr == 2'd3) r_mask <= wb_dat_i[6:0];
    end
  end
endmodule

// File: tb/tb_wb_gpio_btn.sv
// tb_wb_gpio_btn: directed bench for wb_gpio_btn with a read-data scoreboard queue.
module tb_wb_gpio_btn;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] adr = '0, dat_i = '0, dat_o;
  logic [3:0] sel = '0, sw = '0;
  logic [2:0] btn = '0;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0, ack, irq, irq_at_ack = 1'b0;
  logic [7:0] led;
  logic s [16];
  logic [31:0] exp_q [$];
  string tag_q [$];
  int n_tests = 0, n_fail = 0;

  wb_gpio_btn #(.DEBOUNCE_CYCLES(4), .CNT_W(24), .BLINK_BIT(2)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_sel_i(sel), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_ack_o(ack),
    .sw_i(sw), .btn_i(btn), .led_o(led), .irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string t, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, o, e);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s_);
    int n;
    logic [31:0] e;
    string t;
    n = 0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = {28'd0, a, 2'b00}; dat_i = d; sel = s_;
    do begin
      tick();
      n++;
    end while (!ack && n < 8);
    check("ack_lat", n, 1);
    irq_at_ack = irq;
    if (!w) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, dat_o, e);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    check("ack_drop", {31'd0, ack}, 0);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    xfer(1'b0, a, 32'd0, 4'hF);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s_);
    xfer(1'b1, a, d, s_);
  endtask

  initial begin
    tick(3);
    check("rst_led", {24'd0, led}, 0);
    check("rst_irq", {31'd0, irq}, 0);
    check("rst_ack", {31'd0, ack}, 0);
    check("rst_dat", dat_o, 0);
    rst_n = 1'b1;
    tick(2);
    rd(0, 32'h0, "rst_rd_led");
    rd(1, 32'h0, "rst_rd_in");
    rd(2, 32'h0, "rst_rd_edge");
    rd(3, 32'h0, "rst_rd_mask");
    check("rst_led_o", {24'd0, led}, 0);
    check("rst_irq_o", {31'd0, irq}, 0);
    wr(0, 32'h0000_00A5, 4'b0001);
    rd(0, 32'h0000_00A5, "led_rd");
    check("led_o_a5", {24'd0, led}, 32'hA5);
    wr(0, 32'h0000_005A, 4'b0010);
    rd(0, 32'h0000_00A5, "led_sel1_rd");
    check("led_o_sel1", {24'd0, led}, 32'hA5);
    wr(1, 32'h0000_007F, 4'b0001);
    rd(1, 32'h0, "in_ro");
    wr(3, 32'hFFFF_FF55, 4'b0001);
    rd(3, 32'h0000_0055, "mask_rd");
    wr(3, 32'h0, 4'b0001);
    // glitch shorter than the debounce window
    sw[0] = 1'b1;
    tick(3);
    sw[0] = 1'b0;
    tick(8);
    rd(1, 32'h0, "glitch_in");
    rd(2, 32'h0, "glitch_edge");
    // stable press: debounced at the 6th edge after the pin change
    sw[0] = 1'b1;
    tick(5);
    rd(1, 32'h0, "in_edge6_old");
    rd(1, 32'h1, "in_after");
    rd(2, 32'h1, "edge0_set");
    sw[0] = 1'b0;
    tick(8);
    rd(1, 32'h0, "in_release");
    rd(2, 32'h1, "edge_fall_ign");
    wr(2, 32'h1, 4'b0001);
    rd(2, 32'h0, "edge0_w1c");
    // interrupt on btn north (bit 4)
    wr(3, 32'h10, 4'b0001);
    btn[0] = 1'b1;
    tick(6);
    check("irq_lag", {31'd0, irq}, 0);
    tick();
    check("irq_set", {31'd0, irq}, 1);
    rd(2, 32'h10, "edge4_set");
    wr(2, 32'h10, 4'b0001);
    check("irq_at_w1c", {31'd0, irq_at_ack}, 1);
    check("irq_drop", {31'd0, irq}, 0);
    rd(2, 32'h0, "edge4_clr");
    // W1C racing a new rise on btn east (bit 5)
    wr(3, 32'h20, 4'b0001);
    btn[1] = 1'b1;
    tick(10);
    check("irq_b5", {31'd0, irq}, 1);
    btn[1] = 1'b0;
    tick(10);
    rd(2, 32'h20, "edge5_pre");
    btn[1] = 1'b1;
    tick(5);
    wr(2, 32'h20, 4'b0001);
    check("race_irq_ack", {31'd0, irq_at_ack}, 1);
    check("race_irq_after", {31'd0, irq}, 1);
    rd(2, 32'h20, "race_edge");
    check("race_irq_end", {31'd0, irq}, 1);
    wr(0, 32'h0000_0101, 4'b0011);
`ifdef WB_GPIO_LED_BLINK_EN
    rd(0, 32'h0000_0101, "blink_rd");
    for (int i = 0; i < 16; i++) begin
      s[i] = led[0];
      check("blink_hi", {25'd0, led[7:1]}, 0);
      if (i >= 4) check("blink_tgl", {31'd0, s[i]}, {31'd0, ~s[i-4]});
      tick();
    end
`else
    rd(0, 32'h0000_0001, "noblink_rd");
    for (int i = 0; i < 16; i++) begin
      check("noblink_led", {24'd0, led}, 1);
      tick();
    end
`endif
    // reset in the middle of a write
    sw = '0;
    btn = '0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; dat_i = 32'hFF; sel = 4'b0001;
    #3;
    rst_n = 1'b0;
    tick();
    check("rst_mid_ack", {31'd0, ack}, 0);
    check("rst_mid_led", {24'd0, led}, 0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rst_mid_ack2", {31'd0, ack}, 0);
    rd(0, 32'h0, "rst_mid_rd");
    rd(2, 32'h0, "rst_mid_edge");
    check("rst_mid_irq", {31'd0, irq}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
